// File: rtl/upmix_pkg.sv
// Shared types, default widths and helper functions for the I/Q upmixer.
package upmix_pkg;

    // Default build-time parameters for the upmixer and its pipeline.
    localparam int BB_W_DEF  = 12;
    localparam int NCO_W_DEF = 10;
    localparam int OUT_W_DEF = 16;
    localparam int RATE_DEF  = 4;
    localparam int SHIFT_DEF = 5;

    // Control state: IDLE until the first baseband sample arrives, then RUN forever.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of one baseband x carrier product.
    function automatic int prod_w(input int bb_w, input int nco_w);
        return bb_w + nco_w;
    endfunction

    // Width of the exact product difference I*cos - Q*sin.
    function automatic int diff_w(input int bb_w, input int nco_w);
        return prod_w(bb_w, nco_w) + 1;
    endfunction

    // Largest value representable in a signed w-bit word.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed w-bit word.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/upmix_mac.sv
// Multiply / subtract / round / saturate pipeline for pb = I*cos - Q*sin.
// An operand register captures the sample presented with in_valid, followed by
// three arithmetic stages, so a result appears three clken edges after capture.
// All registers advance only when clken is high; data registers only load when
// the valid bit travelling with them is set, so out_pb holds between samples.
module upmix_mac
    import upmix_pkg::*;
#(
    parameter int BB_W  = BB_W_DEF,
    parameter int NCO_W = NCO_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    in_valid,
    input  logic signed [BB_W-1:0]  in_i,
    input  logic signed [BB_W-1:0]  in_q,
    input  logic signed [NCO_W-1:0] in_cos,
    input  logic signed [NCO_W-1:0] in_sin,
    output logic signed [OUT_W-1:0] out_pb,
    output logic                    out_valid
);

    localparam int PW = prod_w(BB_W, NCO_W);
    localparam int DW = diff_w(BB_W, NCO_W);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int AW = DW + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    // Round-half-up constant; zero when no bits are dropped.
    localparam logic signed [AW-1:0] RND = (SHIFT > 0) ? (AW'(1) <<< RND_SH) : '0;
    localparam longint SAT_HI = sat_max(OUT_W);
    localparam longint SAT_LO = sat_min(OUT_W);

    logic                    op_valid_reg;
    logic                    prod_valid_reg;
    logic                    diff_valid_reg;
    logic                    pb_valid_reg;
    logic signed [DW-1:0]    diff_reg;
    logic signed [AW-1:0]    round_next;
    longint                  sat_in;
    logic signed [OUT_W-1:0] pb_next;
    logic signed [OUT_W-1:0] pb_reg;

    // Two identical lanes: lane 0 forms I*cos, lane 1 forms Q*sin.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic signed [BB_W-1:0]  op_bb_reg;
        logic signed [NCO_W-1:0] op_car_reg;
        logic signed [PW-1:0]    prod_reg;

        // Capture operands, then register the full-precision product.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                op_bb_reg  <= '0;
                op_car_reg <= '0;
                prod_reg   <= '0;
            end else if (clken) begin
                if (in_valid) begin
                    op_bb_reg  <= (gi == 0) ? in_i   : in_q;
                    op_car_reg <= (gi == 0) ? in_cos : in_sin;
                end
                if (op_valid_reg) begin
                    prod_reg <= PW'(op_bb_reg) * PW'(op_car_reg);
                end
            end
        end
    end

    // Valid bits shadow the data through every stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_valid_reg   <= 1'b0;
            prod_valid_reg <= 1'b0;
            diff_valid_reg <= 1'b0;
            pb_valid_reg   <= 1'b0;
        end else if (clken) begin
            op_valid_reg   <= in_valid;
            prod_valid_reg <= op_valid_reg;
            diff_valid_reg <= prod_valid_reg;
            pb_valid_reg   <= diff_valid_reg;
        end
    end

    // Exact difference of the two products.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            diff_reg <= '0;
        end else if (clken && prod_valid_reg) begin
            diff_reg <= DW'(g_lane[0].prod_reg) - DW'(g_lane[1].prod_reg);
        end
    end

    // Round half up by dropping SHIFT LSBs, then clamp into the output range.
    always_comb begin
        round_next = AW'(diff_reg) + RND;
        round_next = round_next >>> SHIFT;
        sat_in     = longint'(round_next);
        if (sat_in > SAT_HI) begin
            pb_next = OUT_W'(SAT_HI);
        end else if (sat_in < SAT_LO) begin
            pb_next = OUT_W'(SAT_LO);
        end else begin
            pb_next = OUT_W'(sat_in);
        end
    end

    // Output register; keeps the last sample while no new result arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pb_reg <= '0;
        end else if (clken && diff_valid_reg) begin
            pb_reg <= pb_next;
        end
    end

    assign out_pb    = pb_reg;
    assign out_valid = pb_valid_reg;

endmodule

// File: rtl/iq_upmixer.sv
// Baseband-to-passband upmixer: zero-order holds each I/Q sample for RATE
// carrier steps and streams I*cos - Q*sin through the rounding pipeline.
// A missing sample at the hold boundary is replaced by silence and flagged.
module iq_upmixer
    import upmix_pkg::*;
#(
    parameter int BB_W  = BB_W_DEF,
    parameter int NCO_W = NCO_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int RATE  = RATE_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    nco_valid_i,
    input  logic signed [NCO_W-1:0] fsin_i,
    input  logic signed [NCO_W-1:0] fcos_i,
    input  logic signed [BB_W-1:0]  bb_i_i,
    input  logic signed [BB_W-1:0]  bb_q_i,
    input  logic                    bb_valid_i,
    output logic                    bb_ready_o,
    output logic signed [OUT_W-1:0] pb_o,
    output logic                    pb_valid_o,
    output logic                    underrun_o
);

    localparam int CNT_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic signed [BB_W-1:0] hold_i_reg;
    logic signed [BB_W-1:0] hold_q_reg;

    logic carrier_step;
    logic accept;
    logic at_last;
    logic feed_valid;

    assign carrier_step = clken & nco_valid_i;
    assign at_last      = (cnt_reg == CNT_LAST);
    // Ready in IDLE, and in RUN only while the final step of the current hold is pending.
    assign bb_ready_o   = (state_reg == IDLE) | at_last;
    assign accept       = clken & bb_valid_i & bb_ready_o;
    // Only RUN forwards carrier steps into the arithmetic pipeline.
    assign feed_valid   = (state_reg == RUN) & carrier_step;
    // Sample was due on this step but none was offered: silence is loaded instead.
    assign underrun_o   = (state_reg == RUN) & carrier_step & at_last & ~accept;

    // Control FSM with hold registers and the per-sample carrier step counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            hold_i_reg <= '0;
            hold_q_reg <= '0;
        end else if (clken) begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        hold_i_reg <= bb_i_i;
                        hold_q_reg <= bb_q_i;
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (carrier_step) begin
                        if (!at_last) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end else begin
                            // The step itself used the old sample; the reload applies from the next step.
                            cnt_reg    <= '0;
                            hold_i_reg <= accept ? bb_i_i : '0;
                            hold_q_reg <= accept ? bb_q_i : '0;
                        end
                    end else if (accept) begin
                        // Early delivery while waiting at the boundary: swap the sample, keep the count.
                        hold_i_reg <= bb_i_i;
                        hold_q_reg <= bb_q_i;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    upmix_mac #(
        .BB_W  (BB_W),
        .NCO_W (NCO_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_mac (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .in_valid  (feed_valid),
        .in_i      (hold_i_reg),
        .in_q      (hold_q_reg),
        .in_cos    (fcos_i),
        .in_sin    (fsin_i),
        .out_pb    (pb_o),
        .out_valid (pb_valid_o)
    );

endmodule

// File: tb/tb_iq_upmixer.sv
// Self-checking bench for iq_upmixer: directed scenarios followed by random
// traffic, with expected passband samples queued by the driver and consumed
// by an independent output monitor.
module tb_iq_upmixer;

    localparam int BB_W  = 12;
    localparam int NCO_W = 10;
    localparam int OUT_W = 16;
    localparam int RATE  = 4;
    localparam int SHIFT = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              clken;
    logic              nco_valid_i;
    logic [NCO_W-1:0]  fsin_i;
    logic [NCO_W-1:0]  fcos_i;
    logic [BB_W-1:0]   bb_i_i;
    logic [BB_W-1:0]   bb_q_i;
    logic              bb_valid_i;
    logic              bb_ready_o;
    logic [OUT_W-1:0]  pb_o;
    logic              pb_valid_o;
    logic              underrun_o;

    always #5 clk = ~clk;

    iq_upmixer #(
        .BB_W  (BB_W),
        .NCO_W (NCO_W),
        .OUT_W (OUT_W),
        .RATE  (RATE),
        .SHIFT (SHIFT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clken       (clken),
        .nco_valid_i (nco_valid_i),
        .fsin_i      (fsin_i),
        .fcos_i      (fcos_i),
        .bb_i_i      (bb_i_i),
        .bb_q_i      (bb_q_i),
        .bb_valid_i  (bb_valid_i),
        .bb_ready_o  (bb_ready_o),
        .pb_o        (pb_o),
        .pb_valid_o  (pb_valid_o),
        .underrun_o  (underrun_o)
    );

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_idx = 0;
    int   n_out = 0;

    // Reference model state: is a sample being held, how many carrier steps
    // of it have been spent, and which I/Q value is held.
    bit   m_run = 1'b0;
    int   m_pos = 0;
    int   m_i = 0;
    int   m_q = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Passband value from plain integer arithmetic: round half up, clamp to 16 bits.
    function automatic int ref_pb(input int i, input int q, input int c, input int s);
        longint d;
        longint r;
        d = longint'(i) * longint'(c) - longint'(q) * longint'(s);
        r = (d + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic int srand(input int w);
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    // Count clock edges on which the design was enabled.
    always @(posedge clk) begin
        if (clken) edge_idx <= edge_idx + 1;
    end

    // Monitor: a result is consumed on the enabled edge that follows its appearance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && clken && pb_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("pb_spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("pb #%0d value %0d (expect %0d) edge %0d", n_out, $signed(pb_o), e.val, edge_idx);
                    check("pb_value", $signed(pb_o), e.val);
                    check("pb_latency", edge_idx, e.due);
                    n_out++;
                end
            end
        end
    end

    // One clock of stimulus: drive inputs, check handshake outputs, update the model.
    task automatic cycle(input bit ce, input bit nv, input bit bv,
                         input int i, input int q, input int c, input int s);
        bit   due;
        bit   exp_ready;
        bit   step;
        bit   acc;
        bit   exp_under;
        exp_t e;
        @(posedge clk);
        #1;
        clken       = ce;
        nco_valid_i = nv;
        bb_valid_i  = bv;
        bb_i_i      = 12'(i);
        bb_q_i      = 12'(q);
        fcos_i      = 10'(c);
        fsin_i      = 10'(s);
        #2;
        due       = m_run && (m_pos == RATE - 1);
        exp_ready = !m_run || due;
        step      = ce && nv;
        acc       = ce && bv && exp_ready;
        exp_under = due && step && !acc;
        check("bb_ready", int'(bb_ready_o), int'(exp_ready));
        check("underrun", int'(underrun_o), int'(exp_under));
        if (acc) $display("bb accept I=%0d Q=%0d", i, q);
        if (!m_run) begin
            if (acc) begin
                m_i = i; m_q = q; m_pos = 0; m_run = 1'b1;
            end
        end else if (step) begin
            e.val = ref_pb(m_i, m_q, c, s);
            e.due = edge_idx + 4;
            exp_q.push_back(e);
            if (due) begin
                m_pos = 0;
                m_i = acc ? i : 0;
                m_q = acc ? q : 0;
            end else begin
                m_pos++;
            end
        end else if (acc) begin
            m_i = i; m_q = q;
        end
    endtask

    // Asynchronous reset in the middle of a clock period; outputs must clear at once.
    task automatic async_reset(input int hold_cycles);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_pb", $signed(pb_o), 0);
        check("rst_pb_valid", int'(pb_valid_o), 0);
        check("rst_underrun", int'(underrun_o), 0);
        check("rst_ready", int'(bb_ready_o), 1);
        exp_q.delete();
        m_run = 1'b0; m_pos = 0; m_i = 0; m_q = 0;
        repeat (hold_cycles) @(posedge clk);
        #1;
        clken   = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        clken = 1'b0; nco_valid_i = 1'b0; bb_valid_i = 1'b0;
        bb_i_i = '0; bb_q_i = '0; fsin_i = '0; fcos_i = '0;
        #1 reset_n = 1'b0;
        #2;
        check("init_pb", $signed(pb_o), 0);
        check("init_pb_valid", int'(pb_valid_o), 0);
        check("init_underrun", int'(underrun_o), 0);
        check("init_ready", int'(bb_ready_o), 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle: carrier running, no baseband, nothing must come out.
        repeat (10) cycle(1, 1, 0, 0, 0, 511, 0);
        // Pure in-phase tone, 100 * 511 rounds to 1597.
        repeat (16) cycle(1, 1, 1, 100, 0, 511, 0);
        // Positive then negative saturation.
        repeat (8) cycle(1, 1, 1, 2047, -2048, 511, 511);
        repeat (8) cycle(1, 1, 1, -2048, 2047, 511, 511);
        // Underrun: one boundary without a sample, then recovery.
        repeat (4) cycle(1, 1, 0, 0, 0, 511, 0);
        repeat (12) cycle(1, 1, 1, -700, 300, 400, -200);
        // Clock enable toggling every cycle.
        for (int k = 0; k < 24; k++) begin
            cycle((k % 2) == 0, 1, 1, srand(BB_W), srand(BB_W), srand(NCO_W), srand(NCO_W));
        end
        // Reset with a full pipeline, then a clean restart.
        repeat (6) cycle(1, 1, 1, 1234, -567, 300, 250);
        async_reset(2);
        repeat (12) cycle(1, 1, 1, -321, 654, -400, 123);

        // Random traffic with occasional resets.
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 399) == 0) async_reset(int'($urandom_range(1, 3)));
            cycle($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
                  srand(BB_W), srand(BB_W), srand(NCO_W), srand(NCO_W));
        end

        // Drain the pipeline with no new carrier steps.
        repeat (8) cycle(1, 0, 0, 0, 0, 0, 0);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_upmixer.md
Name: iq_upmixer

Overview:
- Downstream consumer of the `nco` carrier outputs (`fsin_o`, `fcos_o`, `out_valid`).
- Takes OFDM baseband I/Q samples over a valid/ready handshake and holds each one for RATE carrier samples (zero-order hold).
- Forms the real passband sample `I·cos − Q·sin`, then rounds and saturates it for the audio DAC path.
- Sits between the OFDM modulator output and the DAC serializer.

Parameters:
- BB_W, 12, baseband I/Q width, signed two's complement
- NCO_W, 10, carrier sin/cos width, signed; matches the `nco` output width
- OUT_W, 16, passband output width, signed
- RATE, 4, carrier samples per baseband sample; legal range ≥1
- SHIFT, 5, LSBs dropped by rounding before saturation

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clken  in  1  global clock enable; every register update is gated by it
- nco_valid_i  in  1  carrier sample valid (from nco `out_valid`)
- fsin_i  in  NCO_W  carrier sine, signed
- fcos_i  in  NCO_W  carrier cosine, signed
- bb_i_i  in  BB_W  baseband in-phase sample
- bb_q_i  in  BB_W  baseband quadrature sample
- bb_valid_i  in  1  baseband sample valid
- bb_ready_o  out  1  upmixer can take a baseband sample
- pb_o  out  OUT_W  passband sample
- pb_valid_o  out  1  pb_o valid, one cycle per carrier sample processed
- underrun_o  out  1  one-cycle pulse: baseband sample missing when it was due

Behaviour:
- Reset is asynchronous and active-low, and is honoured mid-operation.
  - On reset: state=IDLE, cnt=0, hold regs=0, pipeline valids=0.
  - Outputs after reset: pb_o=0, pb_valid_o=0, underrun_o=0, bb_ready_o=1 (IDLE).
- "Carrier step" = clken & nco_valid_i. "Accept" = clken & bb_valid_i & bb_ready_o.
- When clken=0: all state, counter, pipeline and output registers hold; underrun_o is not asserted.
- FSM states:
  - IDLE: bb_ready_o=1. Carrier steps are discarded and produce no output. On accept: load hold regs, cnt←0, go to RUN.
  - RUN: bb_ready_o = (cnt==RATE-1), a combinational decode of registered cnt. Each carrier step feeds the pipeline with the current hold regs.
    - If cnt<RATE-1: cnt←cnt+1.
    - If cnt==RATE-1: cnt←0. If an accept occurs in the same cycle, load the new sample. If there is no accept, load I=Q=0, pulse underrun_o, and stay in RUN, so output continues with silence.
    - An accept in RUN without a carrier step while cnt==RATE-1 is legal. It loads the hold regs, and the next carrier step uses the new sample with cnt unchanged, then follows the cnt rules.
    - RATE=1: bb_ready_o is permanently 1 in RUN.
- Ordering rule: the carrier step at cnt==RATE-1 uses the old held sample. A sample loaded on that edge applies from the next carrier step.
- Arithmetic pipeline (3 clken-qualified stages, valid bit travels with the data):
  - S1: pi=I·cos, pq=Q·sin, each signed BB_W+NCO_W bits.
  - S2: d=pi−pq, signed BB_W+NCO_W+1 bits, exact.
  - S3: r=(d + 2^(SHIFT−1)) >>> SHIFT (arithmetic shift, round-half-up). Then saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. SHIFT=0 means no rounding term.
- Latency: a carrier step at edge k gives pb_valid_o=1 with its result at edge k+3, assuming clken stays high.
- pb_o holds its last value when pb_valid_o=0.
- Going back to IDLE requires reset; there is no other path.

Decomposition:
- Package `upmix_pkg`:
  - state enum {IDLE, RUN}
  - derived widths: PROD_W=BB_W+NCO_W, DIFF_W=PROD_W+1
  - sat_max/sat_min constant functions
- Sub-module `upmix_mac`: the 3-stage multiply/subtract/round/saturate pipeline with clken and valid pass-through.
- Top module: FSM, hold regs, cnt, handshake, underrun logic.

Test Plan:
- Reset then idle: no bb_valid, nco_valid=1 for 10 cycles → pb_valid_o=0 throughout, bb_ready_o=1, underrun_o=0.
- I=100, Q=0, cos=511, sin=0, RATE=4, continuous carrier → pb_o=1597 starting 3 cycles after the first carrier step following the accept; bb_ready_o high every 4th carrier step.
- Saturation: I=2047, Q=−2048, cos=511, sin=511 → pb_o=32767. I=−2048, Q=2047, cos=511, sin=511 → pb_o=−32768.
- Underrun: feed one sample, withhold bb_valid at cnt==3 → underrun_o pulses once; the next 4 outputs are 0; a later accept resumes non-zero output without reset.
- clken toggled 1/0 alternately during RUN → output sequence identical to the clken=1 run, only stretched in time; no duplicated or lost samples.
- Async reset asserted mid-RUN with a full pipeline → outputs go to the reset values immediately (before the next clk edge); the first accept after release restarts cleanly from IDLE.
